// File: rtl/vga_image_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_image_streamer_if
// Purpose  : Avalon-ST pixel stream bundle between the frame source and the
//            VGA output stage ({R,G,B} x 10 bits, packet = one frame).
// Revision : 1.0  initial release
// ============================================================================
interface vga_image_streamer_if;
    logic [29:0] data;
    logic        startofpacket;
    logic        endofpacket;
    logic        valid;
    logic        ready;

    modport master (output data, output startofpacket, output endofpacket,
                    output valid, input ready);
    modport slave  (input data, input startofpacket, input endofpacket,
                    input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/vga_image_streamer.sv
`default_nettype none
// ============================================================================
// Module   : vga_image_streamer
// Purpose  : Replays one of NUM_IMAGES stored bitmaps as a continuous raster
//            Avalon-ST stream, with integer pixel replication, colour
//            expansion to 8 bits per channel and tear-free image switching.
// Revision : 1.0  initial release
// ============================================================================
module vga_image_streamer #(
    parameter int    H_RES       = 640,
    parameter int    V_RES       = 480,
    parameter int    SCALE       = 1,
    parameter int    COLOUR_BITS = 3,
    parameter int    NUM_IMAGES  = 3,
    parameter string INIT_FILE   = "images.mif",
    localparam int   SEL_W       = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    input  wire logic [SEL_W-1:0]   image_select,
    vga_image_streamer_if.master    src,
    output logic      [SEL_W-1:0]   active_image,
    output logic      [15:0]        frame_count
);

    localparam int SRC_W   = H_RES / SCALE;
    localparam int SRC_H   = V_RES / SCALE;
    localparam int IMG_PIX = SRC_W * SRC_H;
    localparam int DEPTH   = NUM_IMAGES * IMG_PIX;
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int XW      = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW      = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int C       = COLOUR_BITS / 3;

    localparam logic [XW-1:0]    X_LAST    = XW'(H_RES - 1);
    localparam logic [YW-1:0]    Y_LAST    = YW'(V_RES - 1);
    localparam logic [SW-1:0]    S_LAST    = SW'(SCALE - 1);
    localparam logic [AW-1:0]    ROW_STEP  = AW'(SRC_W);
    localparam logic [AW-1:0]    IMG_WORDS = AW'(IMG_PIX);
    localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W + 1)'(NUM_IMAGES);

    localparam logic [0:0] ST_PRIME  = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]             state;
    logic [XW-1:0]          x,  nx;
    logic [YW-1:0]          y,  ny;
    logic [SW-1:0]          sx, nsx;
    logic [SW-1:0]          sy, nsy;
    logic [AW-1:0]          col, ncol;
    logic [AW-1:0]          row_base, nrow;
    logic [AW-1:0]          image_base;
    logic                   blank;
    logic [COLOUR_BITS-1:0] rom [DEPTH];
    logic [COLOUR_BITS-1:0] rom_q;

    logic                   valid, handshake, x_last, y_last, frame_end;
    logic                   latch_sel, sel_bad, next_blank, rd_en;
    logic [AW-1:0]          sel_base, next_base, rd_addr;

    // Replicate a C-bit channel MSB-first into 8 bits (1 -> FF, 10 -> AA).
    function automatic logic [7:0] expand(input logic [C-1:0] v);
        logic [7:0] e;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            e[7-i] = v[C-1-(i % C)];
        end
        return e;
    endfunction

    // Handshake, frame boundary and image-select decode.
    always_comb begin
        valid     = (state == ST_STREAM);
        handshake = valid & src.ready;
        x_last    = (x == X_LAST);
        y_last    = (y == Y_LAST);
        frame_end = handshake & x_last & y_last;
        latch_sel = (state == ST_PRIME) | frame_end;
        sel_bad   = ({1'b0, image_select} >= SEL_LIMIT);
        sel_base  = sel_bad ? '0 : AW'(image_select) * IMG_WORDS;
        next_base = latch_sel ? sel_base : image_base;
        next_blank = latch_sel ? sel_bad : blank;
    end

    // Raster position after the current pixel is consumed.
    always_comb begin
        nx   = x;
        ny   = y;
        nsx  = sx;
        nsy  = sy;
        ncol = col;
        nrow = row_base;
        if (x_last) begin
            nx   = '0;
            nsx  = '0;
            ncol = '0;
            if (y_last) begin
                ny   = '0;
                nsy  = '0;
                nrow = '0;
            end else begin
                ny = y + 1'b1;
                if (sy == S_LAST) begin
                    nsy  = '0;
                    nrow = row_base + ROW_STEP;
                end else begin
                    nsy = sy + 1'b1;
                end
            end
        end else begin
            nx = x + 1'b1;
            if (sx == S_LAST) begin
                nsx  = '0;
                ncol = col + 1'b1;
            end else begin
                nsx = sx + 1'b1;
            end
        end
    end

    // Prefetch address; blanked frames never touch the ROM.
    always_comb begin
        rd_addr = (state == ST_PRIME) ? sel_base : (next_base + nrow + ncol);
        rd_en   = ((state == ST_PRIME) | handshake) & ~next_blank;
    end

    // Single-cycle PRIME after reset, then stream forever.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_PRIME;
            image_base   <= '0;
            blank        <= 1'b0;
            active_image <= '0;
        end else begin
            if (state == ST_PRIME) begin
                state <= ST_STREAM;
            end
            if (latch_sel) begin
                image_base   <= sel_base;
                blank        <= sel_bad;
                active_image <= image_select;
            end
        end
    end

    // Position counters advance only on an accepted pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x        <= '0;
            y        <= '0;
            sx       <= '0;
            sy       <= '0;
            col      <= '0;
            row_base <= '0;
        end else if (handshake) begin
            x        <= nx;
            y        <= ny;
            sx       <= nsx;
            sy       <= nsy;
            col      <= ncol;
            row_base <= nrow;
        end
    end

    // Completed-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= '0;
        end else if (frame_end) begin
            frame_count <= frame_count + 16'd1;
        end
    end

    // Registered ROM read; left without reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rom_q <= rom[rd_addr];
        end
    end

    // Stream outputs; data is forced to zero when not valid or blanked.
    always_comb begin
        src.valid         = valid;
        src.startofpacket = valid & (x == '0) & (y == '0);
        src.endofpacket   = valid & x_last & y_last;
        if (valid && !blank) begin
            src.data = {expand(rom_q[COLOUR_BITS-1 -: C]), 2'b00,
                        expand(rom_q[2*C-1 -: C]),         2'b00,
                        expand(rom_q[C-1:0]),              2'b00};
        end else begin
            src.data = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_image_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_image_streamer
// Purpose  : Self-checking bench for vga_image_streamer (8x4, 2x upscale,
//            6-bit colour, 3 images) against a frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_image_streamer;

    localparam int H   = 8;
    localparam int V   = 4;
    localparam int S   = 2;
    localparam int N   = 3;
    localparam int IMG = (H / S) * (V / S);
    localparam int FR  = H * V;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  image_select = 2'd0;
    logic [1:0]  active_image;
    logic [15:0] frame_count;

    vga_image_streamer_if bus ();

    vga_image_streamer #(
        .H_RES(H), .V_RES(V), .SCALE(S), .COLOUR_BITS(6),
        .NUM_IMAGES(N), .INIT_FILE("")
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .image_select(image_select),
        .src(bus),
        .active_image(active_image),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    logic [5:0]  mem [N*IMG];
    int          vectors = 0;
    int          errors  = 0;
    int          m_pos;
    logic [1:0]  m_img;
    logic [15:0] m_fc;

    // 2-bit channel to 8 bits: the pattern simply repeats four times.
    function automatic logic [7:0] chan(input logic [1:0] v);
        return {4{v}};
    endfunction

    // Expected output word for frame pixel pos of image img.
    function automatic logic [29:0] exp_data(input logic [1:0] img, input int pos);
        int px, py;
        logic [5:0] w;
        if (int'(img) >= N) return '0;
        px = pos % H;
        py = pos / H;
        w  = mem[int'(img) * IMG + (py / S) * (H / S) + px / S];
        return {chan(w[5:4]), 2'b00, chan(w[3:2]), 2'b00, chan(w[1:0]), 2'b00};
    endfunction

    function automatic logic [50:0] exp_tuple();
        return {1'b1, (m_pos == 0), (m_pos == FR - 1), m_img, m_fc, exp_data(m_img, m_pos)};
    endfunction

    function automatic logic [50:0] dut_tuple();
        return {bus.valid, bus.startofpacket, bus.endofpacket, active_image, frame_count, bus.data};
    endfunction

    // Model consumes the current pixel; image_select is taken at frame wrap.
    task automatic model_advance();
        if (m_pos == FR - 1) begin
            m_pos = 0;
            m_fc  = m_fc + 16'd1;
            m_img = image_select;
        end else begin
            m_pos = m_pos + 1;
        end
    endtask

    task automatic do_reset(input logic [1:0] sel);
        @(negedge clk);
        reset_n      = 1'b0;
        image_select = sel;
        bus.ready    = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        m_pos   = 0;
        m_img   = sel;
        m_fc    = 16'd0;
    endtask

    task automatic test_reset();
        logic [50:0] got, want;
        reset_n      = 1'b0;
        image_select = 2'd0;
        bus.ready    = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.valid, bus.startofpacket, bus.endofpacket, bus.data, active_image, frame_count} !== '0) begin
            errors++;
            $display("FAIL reset_values: got v=%b sop=%b eop=%b data=%h img=%0d fc=%0d want all zero",
                     bus.valid, bus.startofpacket, bus.endofpacket, bus.data, active_image, frame_count);
        end
        reset_n = 1'b1;
        m_pos = 0; m_img = 2'd0; m_fc = 16'd0;
        #1;
        vectors++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_prime_valid: got %b want 0", bus.valid);
        end
        @(negedge clk);
        got  = dut_tuple();
        want = {1'b1, 1'b1, 1'b0, 2'd0, 16'd0, exp_data(2'd0, 0)};
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_first_beat: got %h want %h", got, want);
        end
    endtask

    task automatic test_scaling();
        logic [50:0] got, want;
        do_reset(2'd0);
        for (int b = 1; b <= FR + 1; b++) begin
            @(negedge clk);
            got  = dut_tuple();
            want = exp_tuple();
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL scaling beat %0d: got %h want %h", b, got, want);
            end
            model_advance();
        end
    endtask

    task automatic test_frame_select();
        logic [50:0] got, want;
        logic [29:0] colour_exp;
        colour_exp = {8'hAA, 2'b00, 8'h55, 2'b00, 8'hFF, 2'b00};
        do_reset(2'd0);
        for (int b = 1; b <= 3 * FR + 1; b++) begin
            @(negedge clk);
            got  = dut_tuple();
            want = exp_tuple();
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL frame_select beat %0d: got %h want %h", b, got, want);
            end
            if (b == FR + 1) begin
                vectors++;
                if (bus.data !== colour_exp || active_image !== 2'd1) begin
                    errors++;
                    $display("FAIL colour_expand: got data %h img %0d want %h img 1",
                             bus.data, active_image, colour_exp);
                end
            end
            if (b > 2 * FR && b <= 3 * FR) begin
                vectors++;
                if (bus.data !== 30'd0 || active_image !== 2'd3) begin
                    errors++;
                    $display("FAIL out_of_range_black beat %0d: got data %h img %0d want 0 img 3",
                             b, bus.data, active_image);
                end
            end
            if (b == 10)     image_select = 2'd1;
            if (b == FR + 8) image_select = 2'd3;
            if (b == 2 * FR + 3) image_select = 2'd2;
            model_advance();
        end
    endtask

    task automatic test_out_of_range();
        logic [50:0] got, want;
        do_reset(2'd3);
        for (int b = 1; b <= FR + 4; b++) begin
            @(negedge clk);
            got  = dut_tuple();
            want = exp_tuple();
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL out_of_range beat %0d: got %h want %h", b, got, want);
            end
            if (b == 5) image_select = 2'd2;
            model_advance();
        end
    endtask

    task automatic test_back_to_back();
        logic [50:0] got, want;
        bus.ready = 1'b1;
        for (int b = 1; b <= 3 * FR; b++) begin
            @(negedge clk);
            got  = dut_tuple();
            want = exp_tuple();
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL back_to_back beat %0d: got %h want %h", b, got, want);
            end
            image_select = 2'($urandom_range(0, 3));
            model_advance();
        end
    endtask

    task automatic test_backpressure();
        logic [50:0] got, want;
        logic [31:0] held;
        logic        was_stalled;
        int          c;
        do_reset(2'd0);
        bus.ready   = 1'b0;
        was_stalled = 1'b0;
        held        = '0;
        for (c = 0; c < 3000 && m_fc < 16'd3; c++) begin
            @(negedge clk);
            got  = dut_tuple();
            want = exp_tuple();
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL backpressure cycle %0d: got %h want %h", c, got, want);
            end
            if (was_stalled) begin
                vectors++;
                if ({bus.startofpacket, bus.endofpacket, bus.data} !== held) begin
                    errors++;
                    $display("FAIL backpressure_hold cycle %0d: got %h want %h",
                             c, {bus.startofpacket, bus.endofpacket, bus.data}, held);
                end
            end
            held      = {bus.startofpacket, bus.endofpacket, bus.data};
            bus.ready = ($urandom_range(0, 99) < 30);
            was_stalled = ~bus.ready;
            if (bus.ready) model_advance();
        end
        vectors++;
        if (m_fc < 16'd3) begin
            errors++;
            $display("FAIL backpressure_timeout: got %0d frames want 3", m_fc);
        end
        bus.ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (frame_count !== 16'd3) begin
            errors++;
            $display("FAIL backpressure_frames: got %0d want 3", frame_count);
        end
    endtask

    task automatic test_mid_reset();
        logic [50:0] got, want;
        do_reset(2'd0);
        for (int b = 1; b <= FR + 17; b++) begin
            @(negedge clk);
            got  = dut_tuple();
            want = exp_tuple();
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL mid_reset_pre beat %0d: got %h want %h", b, got, want);
            end
            if (b < FR + 17) model_advance();
        end
        #2;
        reset_n      = 1'b0;
        image_select = 2'd1;
        #1;
        vectors++;
        if ({bus.valid, bus.startofpacket, bus.endofpacket, bus.data, active_image, frame_count} !== '0) begin
            errors++;
            $display("FAIL mid_reset_async: got v=%b sop=%b eop=%b data=%h img=%0d fc=%0d want all zero",
                     bus.valid, bus.startofpacket, bus.endofpacket, bus.data, active_image, frame_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m_pos = 0; m_img = 2'd1; m_fc = 16'd0;
        for (int b = 1; b <= 3; b++) begin
            @(negedge clk);
            got  = dut_tuple();
            want = exp_tuple();
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL mid_reset_restart beat %0d: got %h want %h", b, got, want);
            end
            model_advance();
        end
    endtask

    initial begin
        bus.ready = 1'b0;
        for (int k = 0; k < IMG; k++) mem[k] = 6'(k);
        mem[IMG] = 6'b10_01_11;
        for (int k = IMG + 1; k < N * IMG; k++) mem[k] = 6'($urandom_range(0, 63));
        for (int k = 0; k < N * IMG; k++) dut.rom[k] = mem[k];

        test_reset();
        test_scaling();
        test_frame_select();
        test_out_of_range();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
